// File: rtl/horner_sequencer.sv
// Polynomial evaluator: Horner's method on one shared add/multiply ALU under a small FSM.
// Optional build macro HORNER_SAT_EN: saturate ALU results at 2^WIDTH-1 and raise sticky ovf.
module horner_sequencer #(
  parameter int WIDTH   = 8,
  parameter int MAX_DEG = 3,
  parameter int DEG_W   = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [DEG_W-1:0] cfg_deg,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             err,
  output logic             ovf
);

  localparam int IDX_W = (MAX_DEG > 0) ? $clog2(MAX_DEG + 1) : 1;
  localparam logic [DEG_W-1:0] MAX_DEG_L = DEG_W'(MAX_DEG);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD_COEF = 3'd1;
  localparam logic [2:0] S_LOAD_X    = 3'd2;
  localparam logic [2:0] S_MUL       = 3'd3;
  localparam logic [2:0] S_ADD       = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

`ifdef HORNER_SAT_EN
  localparam logic SAT_L = 1'b1;
`else
  localparam logic SAT_L = 1'b0;
`endif

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [DEG_W-1:0] deg_q, deg_d;
  logic [DEG_W-1:0] idx_q, idx_d;
  logic [DEG_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] coef_q [0:MAX_DEG];
  logic [WIDTH-1:0] coef_d [0:MAX_DEG];
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;

  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH-1:0] alu_full_s;
  logic               clamp_s;
  logic [WIDTH-1:0]   alu_res_s;

  // Full-width product and sum; the upper bits reveal whether the result fits in WIDTH
  always_comb begin
    prod_s     = (2*WIDTH)'(acc_q) * (2*WIDTH)'(x_q);
    sum_s      = (WIDTH+1)'(acc_q) + (WIDTH+1)'(coef_q[idx_q[IDX_W-1:0]]);
    alu_full_s = (state_q == S_MUL) ? prod_s : {{(WIDTH-1){1'b0}}, sum_s};
    clamp_s    = SAT_L & (|alu_full_s[2*WIDTH-1:WIDTH]);
    if (clamp_s) begin
      alu_res_s = {WIDTH{1'b1}};
    end else begin
      alu_res_s = alu_full_s[WIDTH-1:0];
    end
  end

  // Next-state logic for the Horner control FSM and its datapath registers
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    x_d     = x_q;
    deg_d   = deg_q;
    idx_d   = idx_q;
    count_d = count_q;
    coef_d  = coef_q;
    err_d   = 1'b0;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_deg > MAX_DEG_L) begin
            err_d = 1'b1;
          end else begin
            deg_d   = cfg_deg;
            count_d = {DEG_W{1'b0}};
            ovf_d   = 1'b0;
            state_d = S_LOAD_COEF;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD_COEF: begin
        if (in_valid) begin
          coef_d[count_q[IDX_W-1:0]] = in_data;
          count_d = count_q + {{(DEG_W-1){1'b0}}, 1'b1};
          if (count_q == deg_q) begin
            state_d = S_LOAD_X;
          end else begin
            state_d = S_LOAD_COEF;
          end
        end else begin
          state_d = S_LOAD_COEF;
        end
      end
      S_LOAD_X: begin
        if (in_valid) begin
          x_d   = in_data;
          acc_d = coef_q[0];
          idx_d = {{(DEG_W-1){1'b0}}, 1'b1};
          if (deg_q == {DEG_W{1'b0}}) begin
            state_d = S_DONE;
          end else begin
            state_d = S_MUL;
          end
        end else begin
          state_d = S_LOAD_X;
        end
      end
      S_MUL: begin
        acc_d   = alu_res_s;
        ovf_d   = ovf_q | clamp_s;
        state_d = S_ADD;
      end
      S_ADD: begin
        acc_d = alu_res_s;
        ovf_d = ovf_q | clamp_s;
        idx_d = idx_q + {{(DEG_W-1){1'b0}}, 1'b1};
        if (idx_q == deg_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_MUL;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset; reset aborts any job in flight
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      acc_q   <= {WIDTH{1'b0}};
      x_q     <= {WIDTH{1'b0}};
      deg_q   <= {DEG_W{1'b0}};
      idx_q   <= {DEG_W{1'b0}};
      count_q <= {DEG_W{1'b0}};
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i <= MAX_DEG; i++) begin
        coef_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      deg_q   <= deg_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i <= MAX_DEG; i++) begin
        coef_q[i] <= coef_d[i];
      end
    end
  end

  assign in_ready  = (state_q == S_LOAD_COEF) || (state_q == S_LOAD_X);
  assign out_valid = (state_q == S_DONE);
  assign out_data  = acc_q;
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_horner_sequencer.sv
// Directed self-checking bench for horner_sequencer; expectations follow HORNER_SAT_EN when defined.
module tb_horner_sequencer;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic [2:0] cfg_deg;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;
  logic       err;
  logic       ovf;

  int pass_cnt  = 0;
  int total_cnt = 0;

`ifdef HORNER_SAT_EN
  localparam logic [7:0] WRAP_EXP = 8'd255;
  localparam logic       WRAP_OVF = 1'b1;
`else
  localparam logic [7:0] WRAP_EXP = 8'd0;
  localparam logic       WRAP_OVF = 1'b0;
`endif

  horner_sequencer #(.WIDTH(8), .MAX_DEG(3), .DEG_W(3)) dut (
    .clk(clk), .resetn(resetn), .start(start), .cfg_deg(cfg_deg),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .err(err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_ovf"}, 32'(ovf), 32'd0);
  endtask

  // Load coefficients back to back (coefs[7:0] is a_n), send x, then measure latency from the x edge.
  task automatic load_job(input string tag, input int deg, input logic [31:0] coefs, input logic [7:0] x);
    start = 1'b1;
    cfg_deg = 3'(deg);
    tick();
    start = 1'b0;
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    check({tag, "_in_ready_load"}, 32'(in_ready), 32'd1);
    for (int i = 0; i <= deg; i++) begin
      in_valid = 1'b1;
      in_data  = coefs[8*i +: 8];
      tick();
    end
    in_data = x;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int deg, input logic [7:0] exp, input logic exp_ovf);
    int n;
    n = 1;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(2*deg + 1));
    check({tag, "_out_data"}, 32'(out_data), 32'(exp));
    check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; cfg_deg = 3'd0;
    in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    resetn = 1'b1;

    // Beats offered while idle must be ignored
    in_valid = 1'b1; in_data = 8'd99;
    tick();
    tick();
    check("idle_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;

    // Quadratic 1*x^2 + 2*x + 3 at x=4 -> 27
    load_job("quad", 2, {8'd0, 8'd3, 8'd2, 8'd1}, 8'd4);
    wait_result("quad", 2, 8'd27, 1'b0);
    release_result("quad");

    // 5*x^2 at x=16 -> 1280: wraps to 0 or saturates to 255
    load_job("wrap", 2, {8'd0, 8'd0, 8'd0, 8'd5}, 8'd16);
    wait_result("wrap", 2, WRAP_EXP, WRAP_OVF);
    release_result("wrap");

    // Degree 0 returns a_0 one edge after x; a new start clears ovf
    load_job("deg0", 0, {8'd0, 8'd0, 8'd0, 8'd7}, 8'd9);
    wait_result("deg0", 0, 8'd7, 1'b0);
    release_result("deg0");

    // Illegal degree
    start = 1'b1; cfg_deg = 3'd4;
    tick();
    start = 1'b0;
    check("illegal_err", 32'(err), 32'd1);
    check("illegal_busy", 32'(busy), 32'd0);
    check("illegal_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("illegal_err_drop", 32'(err), 32'd0);
    check("illegal_in_ready2", 32'(in_ready), 32'd0);

    // Reset during ADD of a degree-3 job
    load_job("midrst", 3, {8'd1, 8'd1, 8'd1, 8'd1}, 8'd2);
    check("midrst_in_mul", 32'(busy), 32'd1);
    tick();
    resetn = 1'b0;
    tick();
    check_all_zero("midrst");
    resetn = 1'b1;
    tick();

    // Fresh degree-1 job 2*x + 3 at x=5 -> 13, then backpressure with a stray start
    load_job("deg1", 1, {8'd0, 8'd0, 8'd3, 8'd2}, 8'd5);
    wait_result("deg1", 1, 8'd13, 1'b0);
    for (int c = 0; c < 5; c++) begin
      start   = (c == 2);
      cfg_deg = 3'd4;
      tick();
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data", 32'(out_data), 32'd13);
      check("bp_err", 32'(err), 32'd0);
    end
    start = 1'b0;
    release_result("deg1");
    check("final_in_ready", 32'(in_ready), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
